// File: rtl/conbus_rr_nxm.sv
// Shared-bus Wishbone interconnect: NM masters, NS slaves, round-robin grant held for a whole cycle.
// Unmapped addresses and slaves that never ack are terminated with m_err_o instead of stalling the bus.
module conbus_rr_nxm #(
    parameter int                  NM      = 2,
    parameter int                  NS      = 4,
    parameter int                  DEC_W   = 3,
    parameter logic [NS*DEC_W-1:0] S_ADDR  = '0,
    parameter int                  TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NM*32-1:0]  m_dat_i,
    input  logic [NM*32-1:0]  m_adr_i,
    input  logic [NM*3-1:0]   m_cti_i,
    input  logic [NM*4-1:0]   m_sel_i,
    input  logic [NM-1:0]     m_we_i,
    input  logic [NM-1:0]     m_cyc_i,
    input  logic [NM-1:0]     m_stb_i,
    output logic [NM*32-1:0]  m_dat_o,
    output logic [NM-1:0]     m_ack_o,
    output logic [NM-1:0]     m_err_o,
    input  logic [NS*32-1:0]  s_dat_i,
    input  logic [NS-1:0]     s_ack_i,
    output logic [NS*32-1:0]  s_dat_o,
    output logic [NS*32-1:0]  s_adr_o,
    output logic [NS*3-1:0]   s_cti_o,
    output logic [NS*4-1:0]   s_sel_o,
    output logic [NS-1:0]     s_we_o,
    output logic [NS-1:0]     s_cyc_o,
    output logic [NS-1:0]     s_stb_o
);

    localparam int          GW      = (NM > 1) ? $clog2(NM) : 1;
    localparam int          SW      = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   gnt, gnt_nxt;
    logic [GW-1:0]   last, last_nxt;
    logic [15:0]     to_cnt;
    logic            unm_q;
    logic            to_q;
    int              cand;

    logic [31:0]     g_adr, g_dat;
    logic [2:0]      g_cti;
    logic [3:0]      g_sel;
    logic            g_we, g_cyc, g_stb;

    logic [NS-1:0]   hit;
    logic            hit_any;
    logic [SW-1:0]   hit_idx;
    logic            own, stb_act, ack_hit;
    logic [31:0]     rd_dat;

    always_comb begin
        g_adr = m_adr_i[32*int'(gnt) +: 32];
        g_dat = m_dat_i[32*int'(gnt) +: 32];
        g_cti = m_cti_i[3*int'(gnt) +: 3];
        g_sel = m_sel_i[4*int'(gnt) +: 4];
        g_we  = m_we_i[gnt];
        g_cyc = m_cyc_i[gnt];
        g_stb = m_stb_i[gnt];
    end

    // Scan from the top so the lowest matching slave index is the one kept.
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (g_adr[31 -: DEC_W] == S_ADDR[k*DEC_W +: DEC_W]) begin
                hit_any = 1'b1;
                hit_idx = SW'(k);
            end
        end
        if (hit_any) begin
            hit[hit_idx] = 1'b1;
        end
    end

    assign own     = (state == OWN);
    assign stb_act = own & g_cyc & g_stb;
    assign ack_hit = hit_any & s_ack_i[hit_idx];
    assign rd_dat  = hit_any ? s_dat_i[32*int'(hit_idx) +: 32] : 32'h0;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        cand      = 0;
        case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_nxt = OWN;
                    // Descending scan: the requester nearest after last is written last.
                    for (int i = NM; i >= 1; i--) begin
                        cand = (int'(last) + i) % NM;
                        if (m_cyc_i[cand]) begin
                            gnt_nxt = GW'(cand);
                        end
                    end
                end
            end
            OWN: begin
                if (!g_cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = gnt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= IDLE;
            gnt    <= '0;
            last   <= GW'(NM - 1);
            to_cnt <= '0;
            unm_q  <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            unm_q <= stb_act & !hit_any & !unm_q;
            to_q  <= stb_act & hit_any & !ack_hit & (to_cnt == TO_LAST);
            if (stb_act && hit_any && !ack_hit && (to_cnt != TO_LAST) && (state_nxt == state)) begin
                to_cnt <= to_cnt + 16'd1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // A slave ack in the error cycle takes priority over the error.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (stb_act) begin
            m_ack_o[gnt] = ack_hit;
            m_err_o[gnt] = !ack_hit & (unm_q | to_q);
        end
    end

    assign m_dat_o = {NM{rd_dat}};
    assign s_dat_o = {NS{g_dat}};
    assign s_adr_o = {NS{g_adr}};
    assign s_cti_o = {NS{g_cti}};
    assign s_sel_o = {NS{g_sel}};
    assign s_we_o  = {NS{g_we}};
    assign s_cyc_o = (own & g_cyc) ? hit : '0;
    assign s_stb_o = stb_act ? hit : '0;

endmodule

// File: tb/tb_conbus_rr_nxm.sv
// Bench for conbus_rr_nxm: three masters, four slaves with per-slave ack latency, timeout of 8 cycles.
// Per-master queues hold the expected termination of each beat; a negedge monitor pops and compares.
module tb_conbus_rr_nxm;

    localparam int NM      = 3;
    localparam int NS      = 4;
    localparam int DEC_W   = 3;
    localparam int TIMEOUT = 8;
    localparam logic [NS*DEC_W-1:0] S_ADDR = {3'd3, 3'd2, 3'd1, 3'd0};

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [NM*32-1:0]  m_dat_i, m_adr_i;
    logic [NM*3-1:0]   m_cti_i;
    logic [NM*4-1:0]   m_sel_i;
    logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i;
    logic [NM*32-1:0]  m_dat_o;
    logic [NM-1:0]     m_ack_o, m_err_o;
    logic [NS*32-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i;
    logic [NS*32-1:0]  s_dat_o, s_adr_o;
    logic [NS*3-1:0]   s_cti_o;
    logic [NS*4-1:0]   s_sel_o;
    logic [NS-1:0]     s_we_o, s_cyc_o, s_stb_o;

    conbus_rr_nxm #(
        .NM(NM), .NS(NS), .DEC_W(DEC_W), .S_ADDR(S_ADDR), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_cti_i(m_cti_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_cti_o(s_cti_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc_no = 0;
    always @(posedge sys_clk) cyc_no <= cyc_no + 1;

    // Slave k acks when its strobe has been waiting lat[k]-1 cycles; lat 0 never acks.
    int            lat [NS];
    int            wcnt [NS];
    logic [31:0]   rd_base [NS];
    logic [NS-1:0] extra_ack = '0;

    always_comb begin
        s_ack_i = '0;
        s_dat_i = '0;
        for (int k = 0; k < NS; k++) begin
            s_ack_i[k] = (s_stb_o[k] && lat[k] != 0 && wcnt[k] == lat[k] - 1) || extra_ack[k];
            s_dat_i[k*32 +: 32] = rd_base[k];
        end
    end

    always @(posedge sys_clk) begin
        for (int k = 0; k < NS; k++) begin
            if (s_stb_o[k] && !s_ack_i[k]) wcnt[k] <= wcnt[k] + 1;
            else                           wcnt[k] <= 0;
        end
    end

    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic [NS-1:0] s_stb;
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic [31:0]   dat;
        logic [31:0]   adr;
        logic [31:0]   wdat;
        logic [3:0]    sel;
        logic          we;
        logic [2:0]    cti;
        int            raise_cyc;
        int            resp_cyc;
    } snap_t;

    exp_t exp_q [NM][$];
    int   resp_log [$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    exp_t mon_e;

    always @(negedge sys_clk) begin
        if (mon_en) begin
            for (int m = 0; m < NM; m++) begin
                if (m_ack_o[m] || m_err_o[m]) begin
                    vectors++;
                    resp_log.push_back(m);
                    if (m_ack_o[m] && m_err_o[m]) begin
                        miscompares++;
                        $display("FAIL m%0d_ack_and_err got ack=1 err=1 want exactly one", m);
                    end else if (exp_q[m].size() == 0) begin
                        miscompares++;
                        $display("FAIL m%0d_unexpected got ack=%b err=%b want none", m, m_ack_o[m], m_err_o[m]);
                    end else begin
                        mon_e = exp_q[m].pop_front();
                        if (m_err_o[m] !== mon_e.err) begin
                            miscompares++;
                            $display("FAIL m%0d_term got err=%b want err=%b", m, m_err_o[m], mon_e.err);
                        end else if (mon_e.chk && m_dat_o[m*32 +: 32] !== mon_e.dat) begin
                            miscompares++;
                            $display("FAIL m%0d_rdata got %h want %h", m, m_dat_o[m*32 +: 32], mon_e.dat);
                        end
                    end
                end
            end
        end
    end

    task automatic m_xfer(input int m, input int beats, input logic [31:0] adr, input logic we,
                          input logic [31:0] wdat, input logic [3:0] sel, input bit exp_err,
                          output snap_t sn);
        exp_t e;
        int   k;
        bit   got;
        @(posedge sys_clk); #1;
        sn.raise_cyc = cyc_no;
        m_cyc_i[m] = 1'b1;
        for (int b = 0; b < beats; b++) begin
            m_adr_i[m*32 +: 32] = adr + 32'(b * 4);
            m_dat_i[m*32 +: 32] = wdat;
            m_sel_i[m*4 +: 4]   = sel;
            m_we_i[m]           = we;
            m_cti_i[m*3 +: 3]   = (beats == 1) ? 3'b000 : (b == beats - 1) ? 3'b111 : 3'b010;
            m_stb_i[m]          = 1'b1;
            k     = int'(adr[31:29]);
            e.err = exp_err;
            e.chk = !we && !exp_err;
            e.dat = (k < NS) ? rd_base[k] : 32'h0;
            exp_q[m].push_back(e);
            got = 1'b0;
            for (int t = 0; t < 64 && !got; t++) begin
                @(negedge sys_clk);
                if (m_ack_o[m] || m_err_o[m]) begin
                    got          = 1'b1;
                    sn.s_stb     = s_stb_o;
                    sn.ack       = m_ack_o;
                    sn.err       = m_err_o;
                    sn.dat       = m_dat_o[m*32 +: 32];
                    sn.adr       = s_adr_o[32 +: 32];
                    sn.wdat      = s_dat_o[32 +: 32];
                    sn.sel       = s_sel_o[4 +: 4];
                    sn.we        = s_we_o[1];
                    sn.cti       = s_cti_o[3 +: 3];
                    sn.resp_cyc  = cyc_no;
                end
            end
            if (!got) begin
                vectors++;
                miscompares++;
                $display("FAIL m%0d_no_response got none after 64 cycles want ack or err", m);
                exp_q[m].delete();
                sn.resp_cyc = -1;
            end
            @(posedge sys_clk); #1;
        end
        m_cyc_i[m] = 1'b0;
        m_stb_i[m] = 1'b0;
        m_we_i[m]  = 1'b0;
    endtask

    task automatic test_reset();
        m_adr_i[31:0]  = 32'h1234_5678;
        m_adr_i[63:32] = 32'h8765_4320;
        #1;
        vectors++;
        if (s_cyc_o !== '0 || s_stb_o !== '0) begin
            miscompares++;
            $display("FAIL rst_slave got cyc=%b stb=%b want 0000", s_cyc_o, s_stb_o);
        end
        vectors++;
        if (m_ack_o !== '0 || m_err_o !== '0) begin
            miscompares++;
            $display("FAIL rst_master got ack=%b err=%b want 000", m_ack_o, m_err_o);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if (s_adr_o[31:0] !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL rst_gnt0 got adr=%h want 12345678", s_adr_o[31:0]);
        end
        m_adr_i = '0;
        mon_en  = 1'b1;
    endtask

    task automatic test_round_robin();
        snap_t s0a, s0b, s1, s2;
        resp_log.delete();
        fork
            begin
                m_xfer(0, 1, 32'h0000_0000, 1'b0, 32'h0, 4'hF, 1'b0, s0a);
                m_xfer(0, 1, 32'h0000_0004, 1'b0, 32'h0, 4'hF, 1'b0, s0b);
            end
            m_xfer(1, 1, 32'h2000_0000, 1'b0, 32'h0, 4'hF, 1'b0, s1);
            m_xfer(2, 1, 32'h4000_0000, 1'b0, 32'h0, 4'hF, 1'b0, s2);
        join
        while (resp_log.size() < 4) resp_log.push_back(-1);
        vectors++;
        if (resp_log[0] != 0 || resp_log[1] != 1 || resp_log[2] != 2 || resp_log[3] != 0) begin
            miscompares++;
            $display("FAIL rr_order got %0d,%0d,%0d,%0d want 0,1,2,0",
                     resp_log[0], resp_log[1], resp_log[2], resp_log[3]);
        end
        // Ack, owner drops cyc, one IDLE cycle, next owner acks: three cycles apart.
        vectors++;
        if (s1.resp_cyc - s0a.resp_cyc != 3) begin
            miscompares++;
            $display("FAIL rr_gap01 got %0d want 3", s1.resp_cyc - s0a.resp_cyc);
        end
        vectors++;
        if (s2.resp_cyc - s1.resp_cyc != 3) begin
            miscompares++;
            $display("FAIL rr_gap12 got %0d want 3", s2.resp_cyc - s1.resp_cyc);
        end
        vectors++;
        if (s0b.resp_cyc - s2.resp_cyc != 3) begin
            miscompares++;
            $display("FAIL rr_gap20 got %0d want 3", s0b.resp_cyc - s2.resp_cyc);
        end
    endtask

    task automatic test_burst_lock();
        snap_t sb, s1;
        resp_log.delete();
        fork
            m_xfer(0, 4, 32'h2000_0000, 1'b0, 32'h0, 4'hF, 1'b0, sb);
            begin
                @(posedge sys_clk);
                m_xfer(1, 1, 32'h4000_0000, 1'b0, 32'h0, 4'hF, 1'b0, s1);
            end
        join
        while (resp_log.size() < 5) resp_log.push_back(-1);
        vectors++;
        if (resp_log[0] != 0 || resp_log[1] != 0 || resp_log[2] != 0 || resp_log[3] != 0 || resp_log[4] != 1) begin
            miscompares++;
            $display("FAIL burst_order got %0d,%0d,%0d,%0d,%0d want 0,0,0,0,1",
                     resp_log[0], resp_log[1], resp_log[2], resp_log[3], resp_log[4]);
        end
        vectors++;
        if (sb.resp_cyc - sb.raise_cyc != 4 || sb.cti !== 3'b111) begin
            miscompares++;
            $display("FAIL burst_timing got span=%0d cti=%b want 4 111", sb.resp_cyc - sb.raise_cyc, sb.cti);
        end
        vectors++;
        if (s1.resp_cyc - sb.resp_cyc != 3) begin
            miscompares++;
            $display("FAIL burst_handover got %0d want 3", s1.resp_cyc - sb.resp_cyc);
        end
    endtask

    task automatic test_decode_read();
        snap_t s;
        rd_base[2] = 32'hDEAD_BEEF;
        m_xfer(1, 1, 32'h4000_0010, 1'b0, 32'h0, 4'hF, 1'b0, s);
        vectors++;
        if (s.s_stb !== 4'b0100) begin
            miscompares++;
            $display("FAIL dec_stb got %b want 0100", s.s_stb);
        end
        vectors++;
        if (s.dat !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL dec_rdata got %h want deadbeef", s.dat);
        end
        vectors++;
        if (s.ack !== 3'b010 || s.err !== 3'b000) begin
            miscompares++;
            $display("FAIL dec_ack got ack=%b err=%b want 010 000", s.ack, s.err);
        end
    endtask

    task automatic test_write();
        snap_t s;
        m_xfer(2, 1, 32'h2000_0040, 1'b1, 32'hCAFE_F00D, 4'b0011, 1'b0, s);
        vectors++;
        if (s.s_stb !== 4'b0010 || s.ack !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_route got stb=%b ack=%b want 0010 100", s.s_stb, s.ack);
        end
        vectors++;
        if (s.adr !== 32'h2000_0040 || s.wdat !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL wr_fields got adr=%h dat=%h want 20000040 cafef00d", s.adr, s.wdat);
        end
        vectors++;
        if (s.sel !== 4'b0011 || s.we !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_ctl got sel=%b we=%b want 0011 1", s.sel, s.we);
        end
    endtask

    task automatic test_unmapped();
        snap_t s;
        extra_ack = 4'b1111;
        m_xfer(0, 1, 32'hE000_0000, 1'b0, 32'h0, 4'hF, 1'b1, s);
        vectors++;
        if (s.err !== 3'b001 || s.ack !== 3'b000) begin
            miscompares++;
            $display("FAIL unm_term got err=%b ack=%b want 001 000", s.err, s.ack);
        end
        vectors++;
        if (s.s_stb !== 4'b0000 || s.dat !== 32'h0) begin
            miscompares++;
            $display("FAIL unm_bus got stb=%b dat=%h want 0000 0", s.s_stb, s.dat);
        end
        vectors++;
        if (s.resp_cyc - s.raise_cyc != 2) begin
            miscompares++;
            $display("FAIL unm_latency got %0d want 2", s.resp_cyc - s.raise_cyc);
        end
        extra_ack = '0;
        repeat (3) @(posedge sys_clk);
    endtask

    task automatic test_timeout();
        snap_t s;
        lat[3] = 0;
        m_xfer(0, 1, 32'h6000_0000, 1'b0, 32'h0, 4'hF, 1'b1, s);
        vectors++;
        if (s.err !== 3'b001 || s.resp_cyc - s.raise_cyc != 9) begin
            miscompares++;
            $display("FAIL to_err got err=%b dly=%0d want 001 9", s.err, s.resp_cyc - s.raise_cyc);
        end
        repeat (3) @(posedge sys_clk);
        lat[3] = 9;
        m_xfer(0, 1, 32'h6000_0000, 1'b0, 32'h0, 4'hF, 1'b0, s);
        vectors++;
        if (s.ack !== 3'b001 || s.err !== 3'b000 || s.resp_cyc - s.raise_cyc != 9) begin
            miscompares++;
            $display("FAIL to_ack_wins got ack=%b err=%b dly=%0d want 001 000 9",
                     s.ack, s.err, s.resp_cyc - s.raise_cyc);
        end
        lat[3] = 8;
        m_xfer(0, 1, 32'h6000_0000, 1'b0, 32'h0, 4'hF, 1'b0, s);
        vectors++;
        if (s.ack !== 3'b001 || s.resp_cyc - s.raise_cyc != 8) begin
            miscompares++;
            $display("FAIL to_ack_late got ack=%b dly=%0d want 001 8", s.ack, s.resp_cyc - s.raise_cyc);
        end
        lat[3] = 1;
        repeat (3) @(posedge sys_clk);
    endtask

    task automatic test_reset_mid();
        mon_en = 1'b0;
        m_adr_i[31:0] = 32'h6000_0004;
        @(posedge sys_clk); #1;
        m_adr_i[63:32] = 32'h0000_0100;
        m_cti_i[5:3]   = 3'b010;
        m_cyc_i[1]     = 1'b1;
        m_stb_i[1]     = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        vectors++;
        if (s_cyc_o !== 4'b0001 || m_ack_o !== 3'b010) begin
            miscompares++;
            $display("FAIL mid_owned got cyc=%b ack=%b want 0001 010", s_cyc_o, m_ack_o);
        end
        #2 sys_rst = 1'b1;
        #1;
        vectors++;
        if (s_cyc_o !== '0 || s_stb_o !== '0) begin
            miscompares++;
            $display("FAIL mid_rst_slave got cyc=%b stb=%b want 0000", s_cyc_o, s_stb_o);
        end
        vectors++;
        if (m_ack_o !== '0 || m_err_o !== '0) begin
            miscompares++;
            $display("FAIL mid_rst_master got ack=%b err=%b want 000", m_ack_o, m_err_o);
        end
        m_cyc_i[1] = 1'b0;
        m_stb_i[1] = 1'b0;
        m_cti_i    = '0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        vectors++;
        if (s_adr_o[31:0] !== 32'h6000_0004 || s_cyc_o !== '0) begin
            miscompares++;
            $display("FAIL mid_gnt0 got adr=%h cyc=%b want 60000004 0000", s_adr_o[31:0], s_cyc_o);
        end
        m_adr_i = '0;
        mon_en  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_dat_i = '0; m_adr_i = '0; m_cti_i = '0; m_sel_i = '0;
        m_we_i  = '0; m_cyc_i = '0; m_stb_i = '0;
        for (int k = 0; k < NS; k++) begin
            lat[k]     = 1;
            rd_base[k] = 32'h1111_1111 * 32'(k + 1);
        end
        test_reset();
        repeat (2) @(posedge sys_clk);
        test_round_robin();
        repeat (2) @(posedge sys_clk);
        test_burst_lock();
        repeat (2) @(posedge sys_clk);
        test_decode_read();
        repeat (2) @(posedge sys_clk);
        test_write();
        repeat (2) @(posedge sys_clk);
        test_unmapped();
        test_timeout();
        test_reset_mid();
        repeat (3) @(posedge sys_clk);
        for (int m = 0; m < NM; m++) begin
            vectors++;
            if (exp_q[m].size() != 0) begin
                miscompares++;
                $display("FAIL m%0d_leftover got %0d pending want 0", m, exp_q[m].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
